// File: rtl/gray_cnt.sv
// Registered up/down Gray-code counter with parallel load.
// Binary and Gray counts are both flop outputs, so gray changes at most one bit per step.
module gray_cnt #(
    parameter int unsigned W        = 4,
    parameter logic [W-1:0] RST_VAL = '0,
    parameter bit           SATURATE = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         up_dn,
    input  logic         load,
    input  logic [W-1:0] load_gray,
    output logic [W-1:0] gray,
    output logic [W-1:0] bin,
    output logic         tc,
    output logic         busy
);

    localparam logic [W-1:0] ALL_ONES = '1;
    localparam logic [W-1:0] ZERO     = '0;
    localparam logic [W-1:0] ONE      = W'(1);
    localparam logic [W-1:0] RST_GRAY = RST_VAL ^ (RST_VAL >> 1);

    logic [W-1:0] bin_nxt;
    logic [W-1:0] gray_nxt;
    logic         tc_nxt;
    logic         busy_nxt;

    // Each binary bit is the XOR of all Gray bits at and above it.
    function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        for (int unsigned i = 0; i < W; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin  <= RST_VAL;
            gray <= RST_GRAY;
            tc   <= 1'b0;
            busy <= 1'b0;
        end else begin
            bin  <= bin_nxt;
            gray <= gray_nxt;
            tc   <= tc_nxt;
            busy <= busy_nxt;
        end
    end

    // Next-count selection: load beats enable; saturation holds at the travel end.
    always_comb begin
        bin_nxt  = bin;
        gray_nxt = gray;
        tc_nxt   = 1'b0;
        busy_nxt = en & ~load;

        if (load) begin
            bin_nxt  = gray2bin(load_gray);
            gray_nxt = load_gray;
        end else if (en) begin
            if (up_dn) begin
                if (bin == ALL_ONES) begin
                    if (!SATURATE) begin
                        bin_nxt = ZERO;
                        tc_nxt  = 1'b1;
                    end
                end else begin
                    bin_nxt = bin + ONE;
                    tc_nxt  = SATURATE && ((bin + ONE) == ALL_ONES);
                end
            end else begin
                if (bin == ZERO) begin
                    if (!SATURATE) begin
                        bin_nxt = ALL_ONES;
                        tc_nxt  = 1'b1;
                    end
                end else begin
                    bin_nxt = bin - ONE;
                    tc_nxt  = SATURATE && ((bin - ONE) == ZERO);
                end
            end
            gray_nxt = bin_nxt ^ (bin_nxt >> 1);
        end
    end

endmodule

// File: tb/tb_gray_cnt.sv
// Self-checking bench for gray_cnt: wrapping and saturating instances against an integer model.
module tb_gray_cnt;

    localparam int unsigned W = 4;
    localparam int M = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         up_dn = 1'b1;
    logic         load = 1'b0;
    logic [W-1:0] load_gray = '0;

    logic [W-1:0] gray_w, bin_w, gray_s, bin_s;
    logic         tc_w, busy_w, tc_s, busy_s;

    int n_chk = 0;
    int n_err = 0;

    int cnt_w, cnt_s;
    bit mtc_w, mtc_s, mbusy;
    logic [W-1:0] prev_gray;

    always #5 clk = ~clk;

    gray_cnt #(.W(W), .RST_VAL(4'd0), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_gray(load_gray),
        .gray(gray_w), .bin(bin_w), .tc(tc_w), .busy(busy_w)
    );

    gray_cnt #(.W(W), .RST_VAL(4'd0), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_gray(load_gray),
        .gray(gray_s), .bin(bin_s), .tc(tc_s), .busy(busy_s)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Gray code of n, by definition.
    function automatic int to_gray(input int n);
        return n ^ (n >> 1);
    endfunction

    // Decode by searching for the count whose Gray code matches.
    function automatic int from_gray(input int g);
        for (int n = 0; n < M; n++) begin
            if (to_gray(n) == g) return n;
        end
        return -1;
    endfunction

    task automatic model_reset();
        cnt_w = 0; cnt_s = 0; mtc_w = 0; mtc_s = 0; mbusy = 0;
    endtask

    task automatic model_step();
        mbusy = en && !load;
        if (load) begin
            cnt_w = from_gray(int'(load_gray));
            cnt_s = cnt_w;
            mtc_w = 0; mtc_s = 0;
        end else if (en && up_dn) begin
            mtc_w = (cnt_w == M - 1);
            cnt_w = (cnt_w + 1) % M;
            if (cnt_s == M - 1) mtc_s = 0;
            else begin cnt_s = cnt_s + 1; mtc_s = (cnt_s == M - 1); end
        end else if (en) begin
            mtc_w = (cnt_w == 0);
            cnt_w = (cnt_w + M - 1) % M;
            if (cnt_s == 0) mtc_s = 0;
            else begin cnt_s = cnt_s - 1; mtc_s = (cnt_s == 0); end
        end else begin
            mtc_w = 0; mtc_s = 0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".bin_w"}, 32'(bin_w), 32'(cnt_w));
        chk({tag, ".gray_w"}, 32'(gray_w), 32'(to_gray(cnt_w)));
        chk({tag, ".tc_w"}, 32'(tc_w), 32'(mtc_w));
        chk({tag, ".busy_w"}, 32'(busy_w), 32'(mbusy));
        chk({tag, ".bin_s"}, 32'(bin_s), 32'(cnt_s));
        chk({tag, ".gray_s"}, 32'(gray_s), 32'(to_gray(cnt_s)));
        chk({tag, ".tc_s"}, 32'(tc_s), 32'(mtc_s));
        chk({tag, ".busy_s"}, 32'(busy_s), 32'(mbusy));
    endtask

    // One clock: sample after the edge, advance the model, compare.
    task automatic tick(input string tag);
        bit was_load;
        was_load = load;
        prev_gray = gray_w;
        @(posedge clk);
        #1;
        model_step();
        check_all(tag);
        if (!was_load) chk({tag, ".onebit"}, 32'($countones(gray_w ^ prev_gray) <= 1), 32'd1);
    endtask

    task automatic async_reset(input string tag);
        rst = 1'b1;
        #2;
        model_reset();
        chk({tag, ".rbin_w"}, 32'(bin_w), 32'd0);
        chk({tag, ".rgray_w"}, 32'(gray_w), 32'd0);
        chk({tag, ".rtc_w"}, 32'(tc_w), 32'd0);
        chk({tag, ".rbusy_w"}, 32'(busy_w), 32'd0);
        chk({tag, ".rbin_s"}, 32'(bin_s), 32'd0);
        chk({tag, ".rbusy_s"}, 32'(busy_s), 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        #12;
        rst = 1'b0;
        check_all("reset");

        // Count to 7, then reset asynchronously mid-cycle.
        en = 1'b1; up_dn = 1'b1;
        for (int i = 0; i < 7; i++) tick("pre_rst");
        chk("at7", 32'(bin_w), 32'd7);
        async_reset("midrst");
        tick("post_rst");
        chk("post_rst_from0", 32'(bin_w), 32'd1);

        // Full up cycle with wrap.
        async_reset("rst2");
        for (int i = 0; i < 16; i++) tick("up16");
        chk("wrap_gray", 32'(gray_w), 32'd0);
        chk("wrap_tc", 32'(tc_w), 32'd1);

        // Load overriding enable, then a down step.
        load = 1'b1; load_gray = 4'b1101;
        tick("load");
        chk("load_bin", 32'(bin_w), 32'b1001);
        load = 1'b0; up_dn = 1'b0;
        tick("down1");
        chk("down_gray", 32'(gray_w), 32'b1100);

        // Down-wrap from zero, then reverse direction.
        load = 1'b1; load_gray = 4'b0000;
        tick("load0");
        load = 1'b0; up_dn = 1'b0;
        tick("dwrap");
        chk("dwrap_gray", 32'(gray_w), 32'b1000);
        chk("dwrap_tc", 32'(tc_w), 32'd1);
        up_dn = 1'b1;
        tick("uwrap");
        chk("uwrap_tc", 32'(tc_w), 32'd1);

        // Saturation from 1101 upward.
        load = 1'b1; load_gray = 4'(to_gray(13));
        tick("load13");
        load = 1'b0; up_dn = 1'b1;
        for (int i = 0; i < 5; i++) tick("sat_up");
        chk("sat_hold", 32'(bin_s), 32'hF);
        chk("sat_gray", 32'(gray_s), 32'b1000);

        // Idle: everything holds, tc drops.
        en = 1'b0;
        tick("idle");

        // Randomised run with occasional loads and asynchronous resets.
        for (int i = 0; i < 1000; i++) begin
            en = 1'($urandom_range(0, 3) != 0);
            up_dn = 1'($urandom);
            load = 1'($urandom_range(0, 9) == 0);
            load_gray = load ? 4'($urandom) : 4'bxxxx;
            tick("rand");
            if ($urandom_range(0, 99) == 0) async_reset("rand_rst");
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
